// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: framed command controller between a UART receiver and a small
// register file that feeds the seven-segment decoders.
//
// Frame format (one byte per i_Rx_DV pulse): SYNC, ADDR, DATA, CSUM where
// CSUM = ADDR ^ DATA. A good frame with ADDR < NUM_REGS writes DATA into
// register ADDR. Checksum errors, out-of-range addresses and inter-byte
// timeouts each bump a saturating error counter.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Rx_DV      one-cycle byte-valid pulse
//   i_Rx_Byte    received byte
//   o_Regs       packed register file, reg k at [8k+7:8k]
//   o_Wr_Stb     one-cycle pulse in the cycle after a committed write
//   o_Wr_Addr    address of the last committed write
//   o_Busy       high while a frame is in progress
//   o_Err_Count  frame error counter, saturates at 255
//   o_Ack_DV     (RX_FRAME_ACK_EN only) ack byte valid, same timing as o_Wr_Stb
//   o_Ack_Byte   (RX_FRAME_ACK_EN only) 8'h06 on commit, 8'h15 on error
//
// Optional feature macro: RX_FRAME_ACK_EN (adds the ack ports and logic).

module rx_frame_ctrl #(
   parameter int unsigned NUM_REGS     = 2,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 8700
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Rx_DV,
   input  logic [7:0]            i_Rx_Byte,
   output logic [8*NUM_REGS-1:0] o_Regs,
   output logic                  o_Wr_Stb,
   output logic [3:0]            o_Wr_Addr,
   output logic                  o_Busy,
   output logic [7:0]            o_Err_Count
`ifdef RX_FRAME_ACK_EN
   ,
   output logic                  o_Ack_DV,
   output logic [7:0]            o_Ack_Byte
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_CSUM = 2'd3;

   localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   // Abort on the edge where the counter would reach TIMEOUT_CLKS-1, so Busy
   // drops exactly TIMEOUT_CLKS-1 cycles after the last byte.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 2);

   logic [1:0]    r_state;
   logic [1:0]    w_state_next;
   logic [7:0]    r_addr;
   logic [7:0]    r_data;
   logic [TW-1:0] r_tmo_cnt;
   logic [7:0]    r_regs [NUM_REGS];
   logic          r_wr_stb;
   logic [3:0]    r_wr_addr;
   logic [7:0]    r_err_cnt;

   logic w_in_frame;
   logic w_timeout;
   logic w_csum_byte;
   logic w_commit;
   logic w_err;

   assign w_in_frame  = (r_state != S_IDLE);
   assign w_timeout   = w_in_frame && !i_Rx_DV && (r_tmo_cnt == TMO_LAST);
   assign w_csum_byte = (r_state == S_CSUM) && i_Rx_DV;
   assign w_commit    = w_csum_byte && (i_Rx_Byte == (r_addr ^ r_data)) &&
                        (r_addr < 8'(NUM_REGS));
   assign w_err       = (w_csum_byte && !w_commit) || w_timeout;

   always_comb begin
      w_state_next = r_state;
      if (w_timeout) begin
         w_state_next = S_IDLE;
      end else if (i_Rx_DV) begin
         case (r_state)
            S_IDLE:  w_state_next = (i_Rx_Byte == SYNC_BYTE) ? S_ADDR : S_IDLE;
            S_ADDR:  w_state_next = S_DATA;
            S_DATA:  w_state_next = S_CSUM;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_state   <= S_IDLE;
         r_addr    <= 8'h00;
         r_data    <= 8'h00;
         r_tmo_cnt <= '0;
         r_wr_stb  <= 1'b0;
         r_wr_addr <= 4'h0;
         r_err_cnt <= 8'h00;
      end else begin
         r_state  <= w_state_next;
         r_wr_stb <= w_commit;
         if (i_Rx_DV && r_state == S_ADDR) r_addr <= i_Rx_Byte;
         if (i_Rx_DV && r_state == S_DATA) r_data <= i_Rx_Byte;
         if (w_commit) r_wr_addr <= r_addr[3:0];
         if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
         // Counter lives only inside a frame; any byte restarts the window.
         if (i_Rx_DV || !w_in_frame || w_timeout) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         end
      end
   end

   always_ff @(posedge i_Clock) begin
      for (int k = 0; k < NUM_REGS; k++) begin
         if (i_Reset) begin
            r_regs[k] <= 8'h00;
         end else if (w_commit && r_addr == 8'(k)) begin
            r_regs[k] <= r_data;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign o_Regs[8*g +: 8] = r_regs[g];
   end

   assign o_Wr_Stb    = r_wr_stb;
   assign o_Wr_Addr   = r_wr_addr;
   assign o_Busy      = w_in_frame;
   assign o_Err_Count = r_err_cnt;

`ifdef RX_FRAME_ACK_EN
   logic       r_ack_dv;
   logic [7:0] r_ack_byte;

   // Every frame that reaches its CSUM byte is acked; timeouts are not.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_ack_dv   <= 1'b0;
         r_ack_byte <= 8'h00;
      end else begin
         r_ack_dv <= w_csum_byte;
         if (w_csum_byte) r_ack_byte <= w_commit ? 8'h06 : 8'h15;
      end
   end

   assign o_Ack_DV   = r_ack_dv;
   assign o_Ack_Byte = r_ack_byte;
`endif

endmodule
